// File: rtl/arbitro_pkg.sv
// Shared definitions for the ingress-to-egress arbiter: word field positions
// and the two-state activity encoding.
package arbitro_pkg;

  localparam int unsigned WORD_SIZE_DEF = 12;
  localparam int unsigned DEST_BITS_DEF = 2;

  // Word layout: [class:2][dest:DEST_BITS][data:rest]
  localparam int unsigned CLASS_MSB = WORD_SIZE_DEF - 1;
  localparam int unsigned DEST_MSB  = WORD_SIZE_DEF - 3;
  localparam int unsigned DATA_MSB  = WORD_SIZE_DEF - 3 - DEST_BITS_DEF;

  // Destination field MSB for an arbitrary word width
  function automatic int unsigned dest_msb(input int unsigned word_size);
    return word_size - 3;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arbitro_param_rr_prio_sel.sv
// Rotating priority selector: grants the first request found when searching
// upward from i_base+1 (mod N). Tying i_base to N-1 gives strict
// lowest-index-first priority.
module rr_prio_sel
  import arbitro_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int unsigned w_j;

  // Search N positions starting after the base, first hit wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_j = (32'(i_base) + k) % N;
      if (!o_valid && i_req[IW'(w_j)]) begin
        o_valid          = 1'b1;
        o_idx            = IW'(w_j);
        o_gnt[IW'(w_j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_param.sv
// Output arbiter between the ingress and egress FIFO banks. Pops one eligible
// ingress head per cycle and pushes it into the egress FIFO named by its
// destination field one cycle later. Egress FIFOs with almost_full raised
// only block the ingress heads routed to them.
// Define ARB_RR_EN for round-robin selection; default is strict priority.
module arbitro_param
  import arbitro_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 12,
  parameter int unsigned FIFO_UNITS = 4,
  parameter int unsigned INDEX      = 2,
  parameter int unsigned DEST_UNITS = 4,
  parameter int unsigned DEST_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [FIFO_UNITS-1:0]           fifo_empty,
  input  logic [FIFO_UNITS*WORD_SIZE-1:0] data_in,
  input  logic [DEST_UNITS-1:0]           almost_full,
  output logic [FIFO_UNITS-1:0]           pop,
  output logic [DEST_UNITS-1:0]           push,
  output logic [WORD_SIZE-1:0]            data_out,
  output logic                            active_out,
  output logic                            idle_out
);

  localparam int unsigned DMSB = dest_msb(WORD_SIZE);

  logic [FIFO_UNITS-1:0] w_req;
  logic [FIFO_UNITS-1:0] w_gnt;
  logic [INDEX-1:0]      w_idx;
  logic [INDEX-1:0]      w_base;
  logic                  w_valid;
  logic [WORD_SIZE-1:0]  w_word;
  logic [DEST_BITS-1:0]  w_word_dest;
  arb_state_t            r_state;
  arb_state_t            w_state_nxt;

  // A FIFO is a candidate when it has a head word and that word's egress is not almost full
  always_comb begin
    w_req = '0;
    for (int i = 0; i < int'(FIFO_UNITS); i++) begin
      w_req[i] = ~fifo_empty[i] &
                 ~almost_full[data_in[i*WORD_SIZE + DMSB -: DEST_BITS]];
    end
  end

`ifdef ARB_RR_EN
  logic [INDEX-1:0] r_ptr;

  // Round-robin pointer remembers the last granted FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= INDEX'(FIFO_UNITS - 1);
    end else if (w_valid) begin
      r_ptr <= w_idx;
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = INDEX'(FIFO_UNITS - 1);
`endif

  rr_prio_sel #(
    .N  (FIFO_UNITS),
    .IW (INDEX)
  ) u_sel (
    .i_req   (w_req),
    .i_base  (w_base),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Granted head word and its routing field
  always_comb begin
    w_word = '0;
    for (int i = 0; i < int'(FIFO_UNITS); i++) begin
      if (w_valid && (w_idx == INDEX'(i))) begin
        w_word = data_in[i*WORD_SIZE +: WORD_SIZE];
      end
    end
    w_word_dest = w_word[DMSB -: DEST_BITS];
  end

  assign pop      = reset ? '0 : w_gnt;
  assign idle_out = (&fifo_empty) && (push == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: active for as long as grants keep coming
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid)  w_state_nxt = ACTIVE;
      ACTIVE:  if (!w_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Egress push, word and activity flag, one cycle behind the pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push       <= '0;
      data_out   <= '0;
      active_out <= 1'b0;
    end else begin
      active_out <= (w_state_nxt == ACTIVE);
      if (w_valid) begin
        push     <= DEST_UNITS'(1) << w_word_dest;
        data_out <= w_word;
      end else begin
        push     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_param.sv
// Self-checking bench for arbitro_param: table of single-cycle vectors plus
// hand sequences for reset, bursts and asynchronous reset mid-transfer.
// Expected pop values carry both strict-priority and round-robin columns.
`timescale 1ns/1ps
module tb_arbitro_param;

  localparam int unsigned WS = 12;
  localparam int unsigned FU = 4;
  localparam int unsigned DU = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [FU-1:0]    fifo_empty;
  logic [FU*WS-1:0] data_in;
  logic [DU-1:0]    almost_full;
  logic [FU-1:0]    pop;
  logic [DU-1:0]    push;
  logic [WS-1:0]    data_out;
  logic             active_out;
  logic             idle_out;

  arbitro_param #(
    .WORD_SIZE  (WS),
    .FIFO_UNITS (FU),
    .INDEX      (2),
    .DEST_UNITS (DU),
    .DEST_BITS  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .data_in     (data_in),
    .almost_full (almost_full),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .active_out  (active_out),
    .idle_out    (idle_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  push;
    logic [11:0] data;
    logic        active;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  fe;
    logic [47:0] din;
    logic [3:0]  af;
    logic [3:0]  pop_sp;
    logic [3:0]  pop_rr;
  } vec_t;

  exp_t        sb[$];
  vec_t        vq[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [3:0]  cur_push;
  logic [11:0] hold_data;
  logic [47:0] all_w;
  logic [47:0] bp_w;

  function automatic logic [11:0] mkw(input logic [1:0] c, input logic [1:0] d,
                                      input logic [7:0] v);
    return {c, d, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic add_vec(input string nm, input logic [3:0] fe, input logic [47:0] din,
                         input logic [3:0] af, input logic [3:0] sp, input logic [3:0] rr);
    vec_t v;
    v.name = nm; v.fe = fe; v.din = din; v.af = af; v.pop_sp = sp; v.pop_rr = rr;
    vq.push_back(v);
  endtask

  // Called just after a rising edge: drive, check pop/idle, then check the registered push
  task automatic apply_cycle(input string nm, input logic [3:0] fe, input logic [47:0] din,
                             input logic [3:0] af, input logic [3:0] exp_pop);
    exp_t        e;
    exp_t        x;
    logic [11:0] w;
    fifo_empty  = fe;
    data_in     = din;
    almost_full = af;
    #1;
    chk({nm, " pop"}, 32'(pop), 32'(exp_pop));
    chk({nm, " idle_out"}, 32'(idle_out), 32'((&fe) && (cur_push == 4'b0)));
    e.push   = 4'b0;
    e.data   = hold_data;
    e.active = (exp_pop != 4'b0);
    for (int i = 0; i < 4; i++) begin
      if (exp_pop[i]) begin
        w      = din[i*12 +: 12];
        e.push = 4'b0001 << w[9:8];
        e.data = w;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({nm, " push"}, 32'(push), 32'(x.push));
    chk({nm, " data_out"}, 32'(data_out), 32'(x.data));
    chk({nm, " active_out"}, 32'(active_out), 32'(x.active));
    cur_push  = x.push;
    hold_data = x.data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] burst_rr [5];
    logic [3:0] skip_rr  [3];
    burst_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    skip_rr  = '{4'b0010, 4'b1000, 4'b0001};

    all_w = {mkw(2'd3, 2'd3, 8'h43), mkw(2'd2, 2'd2, 8'h32),
             mkw(2'd1, 2'd1, 8'h21), mkw(2'd0, 2'd0, 8'h10)};
    bp_w  = {12'hC44, 12'h000, 12'h000, 12'h211};

    // Reset held with every FIFO non-empty
    reset       = 1'b1;
    fifo_empty  = 4'b0000;
    data_in     = all_w;
    almost_full = 4'b0000;
    cur_push    = 4'b0;
    hold_data   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pop", 32'(pop), 32'h0);
    chk("reset push", 32'(push), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset active_out", 32'(active_out), 32'h0);
    reset = 1'b0;
    apply_cycle("rst_release", 4'b0000, all_w, 4'b0000, 4'b0001);

    // Table: name, fifo_empty, data_in, almost_full, pop strict, pop round-robin
    add_vec("single",    4'b1101, {12'h0, 12'h0, 12'h5A3, 12'h0}, 4'b0000, 4'b0010, 4'b0010);
    add_vec("idle1",     4'b1111, {12'h0, 12'h0, 12'h5A3, 12'h0}, 4'b0000, 4'b0000, 4'b0000);
    add_vec("idle2",     4'b1111, {12'h0, 12'h0, 12'h5A3, 12'h0}, 4'b0000, 4'b0000, 4'b0000);
    add_vec("bp_skip",   4'b0110, bp_w,  4'b0100, 4'b1000, 4'b1000);
    add_vec("bp_wait",   4'b1110, bp_w,  4'b0100, 4'b0000, 4'b0000);
    add_vec("bp_drop",   4'b1110, bp_w,  4'b0000, 4'b0001, 4'b0001);
    add_vec("all_free",  4'b0000, all_w, 4'b0000, 4'b0001, 4'b0010);
    add_vec("af_d1",     4'b0000, all_w, 4'b0010, 4'b0001, 4'b0100);
    add_vec("af_d0",     4'b0000, all_w, 4'b0001, 4'b0010, 4'b1000);
    add_vec("af_all",    4'b0000, all_w, 4'b1111, 4'b0000, 4'b0000);
    add_vec("all_free2", 4'b0000, all_w, 4'b0000, 4'b0001, 4'b0001);
    add_vec("only3",     4'b0111, all_w, 4'b0000, 4'b1000, 4'b1000);
    foreach (vq[i]) begin
      apply_cycle(vq[i].name, vq[i].fe, vq[i].din, vq[i].af,
                  RR ? vq[i].pop_rr : vq[i].pop_sp);
    end

    // Sustained contention from a pointer at the last FIFO
    for (int i = 0; i < 5; i++) begin
      apply_cycle($sformatf("burst%0d", i), 4'b0000, all_w, 4'b0000,
                  RR ? burst_rr[i] : 4'b0001);
    end

    // FIFO2 runs empty mid-burst and is skipped without a gap
    for (int i = 0; i < 3; i++) begin
      apply_cycle($sformatf("skip2_%0d", i), 4'b0100, all_w, 4'b0000,
                  RR ? skip_rr[i] : 4'b0001);
    end

    // Leave push=0100 in flight, then reset between edges
    apply_cycle("to_rst", 4'b1011, all_w, 4'b0000, 4'b0100);
    #2;
    fifo_empty = 4'b0000;
    reset      = 1'b1;
    #1;
    chk("async push", 32'(push), 32'h0);
    chk("async data_out", 32'(data_out), 32'h0);
    chk("async active_out", 32'(active_out), 32'h0);
    chk("async pop", 32'(pop), 32'h0);
    sb.delete();
    cur_push  = 4'b0;
    hold_data = 12'h000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_cycle("restart", 4'b0000, all_w, 4'b0000, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
